// File: rtl/mlp_frame_pkg.sv
// Shared definitions for the 12x12 binarized digit frame and the classifier front end.
package mlp_frame_pkg;

    localparam int GRID_N     = 12;
    localparam int FRAME_BITS = 144;
    localparam int LUMA_W     = 8;

    typedef logic [FRAME_BITS-1:0] frame_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ds_state_t;

    // Row-major with row 0 col 0 in the MSB.
    function automatic int bit_index(input int row, input int col);
        return FRAME_BITS - 1 - (row * GRID_N + col);
    endfunction

endpackage

// File: rtl/band_accumulator.sv
// One horizontal band of cell sums, thresholded to GRID_N bits.
// Polarity: FRAME_DS_INVERT_EN marks bright cells (sum >= LIMIT) instead of dark ones.
module band_accumulator
    import mlp_frame_pkg::*;
#(
    parameter int BLK_W  = 20,
    parameter int BLK_H  = 20,
    parameter int THRESH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       add_en,
    input  logic                       restart,
    input  logic                       band_end,
    input  logic [$clog2(GRID_N)-1:0]  cx,
    input  logic [LUMA_W-1:0]          pixel,
    output logic [GRID_N-1:0]          band
);

    localparam int CX_W  = $clog2(GRID_N);
    localparam int ACC_W = $clog2(BLK_W * BLK_H * (2**LUMA_W - 1) + 1);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(THRESH * BLK_W * BLK_H);

    for (genvar i = 0; i < GRID_N; i++) begin : g_cell
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] sum;

        // A restart discards the old partial sum so the current pixel opens a fresh cell.
        assign sum = (restart ? '0 : acc)
                   + ((add_en && cx == CX_W'(i)) ? ACC_W'(pixel) : '0);

`ifdef FRAME_DS_INVERT_EN
        assign band[i] = (sum >= LIMIT);
`else
        assign band[i] = (sum < LIMIT);
`endif

        always_ff @(posedge clk) begin
            if (rst || band_end) begin
                acc <= '0;
            end else if (restart || add_en) begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/frame_downsampler.sv
// Box-averages a grayscale pixel stream into a 12x12 one-bit frame for the MLP classifier.
// Build option FRAME_DS_INVERT_EN (in band_accumulator) selects light-on-dark polarity.
module frame_downsampler
    import mlp_frame_pkg::*;
#(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 240,
    parameter int GRID   = 12,
    parameter int THRESH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [LUMA_W-1:0]     pix_luma,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_busy,
    output logic                  frame_drop
);

    localparam int BLK_W = IMG_W / GRID;
    localparam int BLK_H = IMG_H / GRID;
    localparam int PX_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int PY_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int CX_W  = $clog2(GRID_N);

    // pix_valid qualifies pix_sof and pix_luma; there is no ready, every valid pixel is consumed.
    ds_state_t         state, state_next;
    logic [PX_W-1:0]   px, px_base, px_next;
    logic [PY_W-1:0]   py, py_base, py_next;
    logic [CX_W-1:0]   cx, cx_base, cx_next;
    logic [CX_W-1:0]   cy, cy_base, cy_next;
    logic              take, first, resync, band_end, frame_end;
    logic [GRID_N-1:0] band;
    frame_t            work, work_next;

    always_comb begin
        state_next = state;
        take       = 1'b0;
        first      = 1'b0;
        resync     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pix_valid && pix_sof) begin
                    take       = 1'b1;
                    first      = 1'b1;
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pix_valid) begin
                    take   = 1'b1;
                    first  = pix_sof;
                    resync = pix_sof;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        px_base = first ? '0 : px;
        py_base = first ? '0 : py;
        cx_base = first ? '0 : cx;
        cy_base = first ? '0 : cy;

        band_end  = take && px_base == PX_W'(BLK_W - 1) && cx_base == CX_W'(GRID_N - 1)
                         && py_base == PY_W'(BLK_H - 1);
        frame_end = band_end && cy_base == CX_W'(GRID_N - 1);
        if (frame_end) state_next = ST_IDLE;

        px_next = px_base;
        py_next = py_base;
        cx_next = cx_base;
        cy_next = cy_base;
        if (px_base != PX_W'(BLK_W - 1)) begin
            px_next = px_base + 1'b1;
        end else begin
            px_next = '0;
            if (cx_base != CX_W'(GRID_N - 1)) begin
                cx_next = cx_base + 1'b1;
            end else begin
                cx_next = '0;
                if (py_base != PY_W'(BLK_H - 1)) begin
                    py_next = py_base + 1'b1;
                end else begin
                    py_next = '0;
                    cy_next = (cy_base == CX_W'(GRID_N - 1)) ? '0 : cy_base + 1'b1;
                end
            end
        end
    end

    // Current band merged into the work register, so frame end needs no extra cycle.
    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            localparam int IDX = bit_index(r, c);
            assign work_next[IDX] = (cy_base == CX_W'(r)) ? band[c] : work[IDX];
        end
    end

    band_accumulator #(
        .BLK_W  (BLK_W),
        .BLK_H  (BLK_H),
        .THRESH (THRESH)
    ) u_band_acc (
        .clk      (clk),
        .rst      (rst),
        .add_en   (take),
        .restart  (first),
        .band_end (band_end),
        .cx       (cx_base),
        .pixel    (pix_luma),
        .band     (band)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            px          <= '0;
            py          <= '0;
            cx          <= '0;
            cy          <= '0;
            work        <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            state       <= state_next;
            frame_valid <= frame_end;
            frame_drop  <= resync;
            if (take) begin
                px <= px_next;
                py <= py_next;
                cx <= cx_next;
                cy <= cy_next;
            end
            if (band_end)  work      <= work_next;
            if (frame_end) frame_out <= work_next;
        end
    end

    assign frame_busy = (state == ST_ACTIVE);

endmodule

// File: tb/tb_frame_downsampler.sv
// Directed bench for frame_downsampler on a reduced 48x36 image (4x3 pixel cells).
// Expectations flip under FRAME_DS_INVERT_EN.
module tb_frame_downsampler;
    import mlp_frame_pkg::*;

    localparam int IMG_W  = 48;
    localparam int IMG_H  = 36;
    localparam int BLK_W  = IMG_W / 12;
    localparam int BLK_H  = IMG_H / 12;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int LIMIT  = 128 * BLK_W * BLK_H;

    logic         clk;
    logic         rst;
    logic         pix_valid;
    logic         pix_sof;
    logic [7:0]   pix_luma;
    logic [143:0] frame_out;
    logic         frame_valid;
    logic         frame_busy;
    logic         frame_drop;

    frame_downsampler #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .GRID   (12),
        .THRESH (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_luma    (pix_luma),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_busy  (frame_busy),
        .frame_drop  (frame_drop)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   cyc = 0;
    int   valid_cnt = 0;
    int   drop_cnt = 0;
    int   valid_cyc = 0;
    int   last_pix_cyc = 0;
    bit   busy_lo_seen, busy_hi_seen;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] img [NPIX];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                valid_cnt <= valid_cnt + 1;
                valid_cyc <= cyc;
            end
            if (frame_drop) drop_cnt <= drop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t pol(input frame_t f);
`ifdef FRAME_DS_INVERT_EN
        return ~f;
`else
        return f;
`endif
    endfunction

    // Reference: direct per-cell sum over the stored image.
    function automatic frame_t model_frame();
        frame_t f = '0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                int sum = 0;
                for (int y = 0; y < BLK_H; y++)
                    for (int x = 0; x < BLK_W; x++)
                        sum += int'(img[(r * BLK_H + y) * IMG_W + c * BLK_W + x]);
                f[143 - (r * 12 + c)] = (sum < LIMIT);
            end
        end
        return f;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int k = 0; k < NPIX; k++) img[k] = v;
    endtask

    task automatic fill_bar();
        for (int k = 0; k < NPIX; k++)
            img[k] = ((k % IMG_W) >= 5 * BLK_W && (k % IMG_W) < 6 * BLK_W) ? 8'd0 : 8'd255;
    endtask

    task automatic fill_cell00(input logic [7:0] v);
        for (int k = 0; k < NPIX; k++)
            img[k] = ((k % IMG_W) < BLK_W && (k / IMG_W) < BLK_H) ? v : 8'd255;
    endtask

    task automatic fill_random();
        int base [12][12];
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++) base[r][c] = int'($urandom_range(0, 255));
        for (int k = 0; k < NPIX; k++) begin
            int v = base[(k / IMG_W) / BLK_H][(k % IMG_W) / BLK_W] + int'($urandom_range(0, 30)) - 15;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            img[k] = 8'(v);
        end
    endtask

    // driver
    task automatic drive_frame(input int n_pix, input int gap_pct, input bit with_sof, input bit sof_last);
        busy_lo_seen = 1'b0;
        busy_hi_seen = 1'b0;
        for (int k = 0; k < n_pix; k++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                @(posedge clk); #1;
                if (k > 0) begin
                    if (frame_busy) busy_hi_seen = 1'b1; else busy_lo_seen = 1'b1;
                end
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
            end
            @(posedge clk); #1;
            if (k > 0) begin
                if (frame_busy) busy_hi_seen = 1'b1; else busy_lo_seen = 1'b1;
            end
            pix_valid    = 1'b1;
            pix_sof      = (with_sof && k == 0) || (sof_last && k == n_pix - 1);
            pix_luma     = img[k];
            last_pix_cyc = cyc;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic run_full(input string tag, input frame_t exp, input int exp_drops, input int gap_pct);
        int v0 = valid_cnt;
        int d0 = drop_cnt;
        drive_frame(NPIX, gap_pct, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, " valid_count"}, valid_cnt - v0, 1);
        check({tag, " latency"}, valid_cyc, last_pix_cyc + 1);
        check({tag, " frame_out"}, frame_out, pol(exp));
        check({tag, " drops"}, drop_cnt - d0, exp_drops);
        check({tag, " busy_gap"}, busy_lo_seen, 0);
        check({tag, " busy_after"}, frame_busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " frame_out"}, frame_out, 0);
        check({tag, " frame_valid"}, frame_valid, 0);
        check({tag, " frame_busy"}, frame_busy, 0);
        check({tag, " frame_drop"}, frame_drop, 0);
    endtask

    frame_t bar_exp, cell_exp, rnd_exp, all_ones;

    initial begin
        int v0, d0;
        bar_exp  = {12{12'h040}};
        cell_exp = {1'b1, 143'b0};
        all_ones = {144{1'b1}};
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_luma = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset");

        fill_const(8'd255);
        run_full("white", '0, 0, 0);
        fill_const(8'd0);
        run_full("black", all_ones, 0, 0);
        fill_bar();
        run_full("bar", bar_exp, 0, 0);
        fill_cell00(8'd128);
        run_full("thr128", '0, 0, 0);
        fill_cell00(8'd127);
        run_full("thr127", cell_exp, 0, 0);

        fill_random();
        rnd_exp = model_frame();
        run_full("gaps", rnd_exp, 0, 30);

        // Resync mid-frame: partial, then a new sof abandons it.
        fill_bar();
        v0 = valid_cnt;
        d0 = drop_cnt;
        drive_frame(1000, 0, 1'b1, 1'b0);
        drive_frame(500, 0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("resync drop", drop_cnt - d0, 1);
        check("resync no_valid", valid_cnt - v0, 0);
        check("resync retained", frame_out, pol(rnd_exp));
        check("resync busy", frame_busy, 1);
        run_full("after_resync", bar_exp, 1, 0);

        // sof on the frame-end pixel is a resync, not a completion.
        fill_const(8'd255);
        v0 = valid_cnt;
        d0 = drop_cnt;
        drive_frame(NPIX, 0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("sof_last drop", drop_cnt - d0, 1);
        check("sof_last no_valid", valid_cnt - v0, 0);
        check("sof_last retained", frame_out, pol(bar_exp));
        fill_const(8'd0);
        run_full("after_sof_last", all_ones, 1, 0);

        // Reset mid-frame, then sof-less pixels must be ignored.
        fill_bar();
        drive_frame(700, 0, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("mid_reset");
        v0 = valid_cnt;
        d0 = drop_cnt;
        drive_frame(500, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("no_sof busy", busy_hi_seen, 0);
        check("no_sof valid", valid_cnt - v0, 0);
        check("no_sof drop", drop_cnt - d0, 0);
        run_full("post_reset", bar_exp, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
